// File: rtl/turf_fragment_reassembler.sv
// turf_fragment_reassembler: reassembles tagged UDP fragments into one transaction stream
// with a per-transaction completion status and an abort path for broken sequences.
module turf_fragment_reassembler #(
    parameter logic [15:0] CONSTANT_0 = 16'hDA7A,
    parameter logic [5:0]  CONSTANT_1 = 6'h00
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [63:0] s_hdr_tdata,
    input  logic        s_hdr_tvalid,
    output logic        s_hdr_tready,
    input  logic [63:0] s_payload_tdata,
    input  logic [7:0]  s_payload_tkeep,
    input  logic        s_payload_tlast,
    input  logic        s_payload_tvalid,
    output logic        s_payload_tready,
    output logic [63:0] m_data_tdata,
    output logic [7:0]  m_data_tkeep,
    output logic        m_data_tlast,
    output logic        m_data_tuser,
    output logic        m_data_tvalid,
    input  logic        m_data_tready,
    output logic [31:0] m_ctrl_tdata,
    output logic        m_ctrl_tuser,
    output logic        m_ctrl_tvalid,
    input  logic        m_ctrl_tready,
    output logic [15:0] err_count_o
);
    typedef enum logic [2:0] {IDLE, TAG, STREAM, DROP, FLUSH, STATUS} state_t;
    state_t      state_q, state_d;
    logic        in_txn_q, in_txn_d, abort_q, abort_d, open_q, open_d;
    logic [9:0]  exp_frag_q, exp_frag_d;
    logic [11:0] addr_q, addr_d;
    logic [19:0] len_q, len_d, rem_q, rem_d;
    logic [15:0] fb_q, fb_d, err_q, err_d;
    logic        hdr_fire, pay_fire, tag_ok, frag_end;
    logic [19:0] rem_eff, rem_dec;
    logic [15:0] fb_dec;
    logic        unused_hdr;

    assign unused_hdr = ^s_hdr_tdata[63:16];
    assign err_count_o = err_q;

    always_comb begin
        s_hdr_tready     = aresetn && state_q == IDLE;
        s_payload_tready = aresetn && (state_q == TAG || state_q == DROP || (state_q == STREAM && m_data_tready));
        m_data_tvalid    = aresetn && ((state_q == STREAM && s_payload_tvalid) || state_q == FLUSH);
        m_data_tdata     = state_q == STREAM ? s_payload_tdata : 64'd0;
        m_data_tkeep     = state_q == STREAM ? s_payload_tkeep : 8'd0;
        m_data_tlast     = state_q == STREAM ? rem_q <= 20'd8 : state_q == FLUSH;
        m_data_tuser     = state_q == FLUSH;
        m_ctrl_tvalid    = aresetn && state_q == STATUS;
        m_ctrl_tdata     = {addr_q, len_q};
        m_ctrl_tuser     = abort_q;
    end

    assign hdr_fire = s_hdr_tvalid && s_hdr_tready;
    assign pay_fire = s_payload_tvalid && s_payload_tready;
    // A continuing fragment is bounded by the held remainder; a first one by its own tag length.
    assign rem_eff  = in_txn_q ? rem_q : s_payload_tdata[19:0];
    assign tag_ok   = s_payload_tdata[63:48] == CONSTANT_0 && s_payload_tdata[47:42] == CONSTANT_1 &&
                      !s_payload_tlast && {4'd0, fb_q} <= rem_eff &&
                      (in_txn_q ? (s_payload_tdata[41:32] == exp_frag_q && s_payload_tdata[31:20] == addr_q &&
                                   s_payload_tdata[19:0] == len_q)
                                : s_payload_tdata[41:32] == 10'd0);
    assign rem_dec  = rem_q - (rem_q > 20'd8 ? 20'd8 : rem_q);
    assign fb_dec   = fb_q - (fb_q > 16'd8 ? 16'd8 : fb_q);
    assign frag_end = fb_q <= 16'd8;

    always_comb begin
        state_d    = state_q;
        in_txn_d   = in_txn_q;
        abort_d    = abort_q;
        open_d     = open_q;
        exp_frag_d = exp_frag_q;
        addr_d     = addr_q;
        len_d      = len_q;
        rem_d      = rem_q;
        fb_d       = fb_q;
        err_d      = err_q;
        case (state_q)
            IDLE: if (hdr_fire) begin
                fb_d    = s_hdr_tdata[15:0] - 16'd8;
                state_d = s_hdr_tdata[15:0] < 16'd9 ? DROP : TAG;
            end
            TAG: if (pay_fire) begin
                if (tag_ok) begin
                    if (!in_txn_q) begin
                        addr_d     = s_payload_tdata[31:20];
                        len_d      = s_payload_tdata[19:0];
                        rem_d      = s_payload_tdata[19:0];
                        exp_frag_d = 10'd1;
                        in_txn_d   = 1'b1;
                    end else begin
                        exp_frag_d = exp_frag_q + 10'd1;
                    end
                    state_d = STREAM;
                end else begin
                    err_d   = err_q == 16'hFFFF ? err_q : err_q + 16'd1;
                    open_d  = !s_payload_tlast;
                    state_d = in_txn_q ? FLUSH : (s_payload_tlast ? IDLE : DROP);
                end
            end
            STREAM: if (pay_fire) begin
                rem_d = rem_dec;
                fb_d  = fb_dec;
                if (frag_end && s_payload_tlast) begin
                    open_d  = 1'b0;
                    state_d = rem_dec == 20'd0 ? STATUS : IDLE;
                end else if (frag_end || s_payload_tlast) begin
                    open_d  = !s_payload_tlast;
                    state_d = FLUSH;
                end
            end
            FLUSH: if (m_data_tready) begin
                abort_d = 1'b1;
                state_d = STATUS;
            end
            STATUS: if (m_ctrl_tready) begin
                in_txn_d = 1'b0;
                abort_d  = 1'b0;
                state_d  = open_q ? DROP : IDLE;
            end
            DROP: if (pay_fire && s_payload_tlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            in_txn_q   <= 1'b0;
            abort_q    <= 1'b0;
            open_q     <= 1'b0;
            exp_frag_q <= 10'd0;
            addr_q     <= 12'd0;
            len_q      <= 20'd0;
            rem_q      <= 20'd0;
            fb_q       <= 16'd0;
            err_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            in_txn_q   <= in_txn_d;
            abort_q    <= abort_d;
            open_q     <= open_d;
            exp_frag_q <= exp_frag_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            fb_q       <= fb_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_turf_fragment_reassembler.sv
// tb_turf_fragment_reassembler: directed scenarios for the fragment reassembler,
// collecting output beats at the falling edge and comparing against hand-built expectations.
module tb_turf_fragment_reassembler;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [63:0] s_hdr_tdata = '0;
    logic        s_hdr_tvalid = 1'b0;
    logic        s_hdr_tready;
    logic [63:0] s_payload_tdata = '0;
    logic [7:0]  s_payload_tkeep = '0;
    logic        s_payload_tlast = 1'b0;
    logic        s_payload_tvalid = 1'b0;
    logic        s_payload_tready;
    logic [63:0] m_data_tdata;
    logic [7:0]  m_data_tkeep;
    logic        m_data_tlast, m_data_tuser, m_data_tvalid;
    logic        m_data_tready = 1'b1;
    logic [31:0] m_ctrl_tdata;
    logic        m_ctrl_tuser, m_ctrl_tvalid;
    logic        m_ctrl_tready = 1'b1;
    logic [15:0] err_count_o;
    logic        tog_en = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic [73:0] dq[$];
    logic [32:0] cq[$];

    turf_fragment_reassembler dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_hdr_tdata(s_hdr_tdata), .s_hdr_tvalid(s_hdr_tvalid), .s_hdr_tready(s_hdr_tready),
        .s_payload_tdata(s_payload_tdata), .s_payload_tkeep(s_payload_tkeep),
        .s_payload_tlast(s_payload_tlast), .s_payload_tvalid(s_payload_tvalid),
        .s_payload_tready(s_payload_tready),
        .m_data_tdata(m_data_tdata), .m_data_tkeep(m_data_tkeep), .m_data_tlast(m_data_tlast),
        .m_data_tuser(m_data_tuser), .m_data_tvalid(m_data_tvalid), .m_data_tready(m_data_tready),
        .m_ctrl_tdata(m_ctrl_tdata), .m_ctrl_tuser(m_ctrl_tuser), .m_ctrl_tvalid(m_ctrl_tvalid),
        .m_ctrl_tready(m_ctrl_tready), .err_count_o(err_count_o)
    );

    initial forever #5 aclk = ~aclk;

    initial forever begin
        @(posedge aclk);
        #1;
        m_data_tready = tog_en ? ~m_data_tready : 1'b1;
    end

    // Handshakes seen at the falling edge complete on the following rising edge.
    initial forever begin
        @(negedge aclk);
        if (aresetn && m_data_tvalid && m_data_tready)
            dq.push_back({m_data_tuser, m_data_tlast, m_data_tkeep, m_data_tdata});
        if (aresetn && m_ctrl_tvalid && m_ctrl_tready)
            cq.push_back({m_ctrl_tuser, m_ctrl_tdata});
    end

    task automatic apply_reset();
        s_hdr_tvalid = 1'b0;
        s_payload_tvalid = 1'b0;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        dq.delete();
        cq.delete();
    endtask

    task automatic send_hdr(input logic [15:0] len);
        int n = 0;
        s_hdr_tdata = {32'hC0A80001, 16'd5000, len};
        s_hdr_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_hdr_tready && n < 200) begin
            n++;
            @(negedge aclk);
        end
        if (!s_hdr_tready) begin
            total++; bad++;
            $display("FAIL hdr_timeout: tready=%0b after %0d cycles, required 1", s_hdr_tready, n);
        end
        @(posedge aclk);
        #1;
        s_hdr_tvalid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n = 0;
        s_payload_tdata = d;
        s_payload_tkeep = k;
        s_payload_tlast = l;
        s_payload_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_payload_tready && n < 200) begin
            n++;
            @(negedge aclk);
        end
        if (!s_payload_tready) begin
            total++; bad++;
            $display("FAIL payload_timeout: tready=%0b after %0d cycles, required 1", s_payload_tready, n);
        end
        @(posedge aclk);
        #1;
        s_payload_tvalid = 1'b0;
    endtask

    task automatic send_dgram(input logic [15:0] len, input logic [63:0] tag, input int nb,
                              input logic [7:0] lastkeep, input logic [63:0] base);
        send_hdr(len);
        send_beat(tag, 8'hFF, 1'b0);
        for (int i = 0; i < nb; i++)
            send_beat(base + 64'(i), i == nb - 1 ? lastkeep : 8'hFF, i == nb - 1);
    endtask

    task automatic settle();
        repeat (8) @(negedge aclk);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        s_payload_tvalid = 1'b1;
        repeat (2) @(negedge aclk);
        total++;
        if ({s_hdr_tready, s_payload_tready, m_data_tvalid, m_ctrl_tvalid} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_handshakes: got %b, required 0000",
                     {s_hdr_tready, s_payload_tready, m_data_tvalid, m_ctrl_tvalid});
        end
        total++;
        if (err_count_o !== 16'd0) begin
            bad++; $display("FAIL reset_err: got %0d, required 0", err_count_o);
        end
        apply_reset();
        @(negedge aclk);
        total++;
        if ({s_hdr_tready, s_payload_tready} !== 2'b10) begin
            bad++; $display("FAIL reset_idle_ready: got %b, required 10", {s_hdr_tready, s_payload_tready});
        end
    endtask

    task automatic test_two_frag();
        logic [63:0] base = 64'h1111_0000_0000_0000;
        logic [73:0] e;
        apply_reset();
        send_dgram(16'd80, 64'hDA7A0000_12300064, 9, 8'hFF, base);
        send_dgram(16'd36, 64'hDA7A0001_12300064, 4, 8'h0F, base + 64'd9);
        settle();
        total++;
        if (dq.size() != 13) begin
            bad++; $display("FAIL two_frag_count: got %0d, required 13", dq.size());
        end
        for (int j = 0; j < 13 && j < dq.size(); j++) begin
            e = {1'b0, j == 12, j == 12 ? 8'h0F : 8'hFF, base + 64'(j)};
            total++;
            if (dq[j] !== e) begin
                bad++; $display("FAIL two_frag_beat%0d: got %h, required %h", j, dq[j], e);
            end
        end
        total++;
        if (cq.size() != 1 || cq[0] !== {1'b0, 32'h12300064}) begin
            bad++; $display("FAIL two_frag_ctrl: got n=%0d %h, required n=1 012300064", cq.size(), cq.size() ? cq[0] : 33'h0);
        end
        total++;
        if (err_count_o !== 16'd0) begin
            bad++; $display("FAIL two_frag_err: got %0d, required 0", err_count_o);
        end
    endtask

    task automatic test_bad_magic();
        apply_reset();
        send_dgram(16'd24, 64'hBEEF0000_12300010, 2, 8'hFF, 64'h2222);
        settle();
        total++;
        if (dq.size() != 0 || cq.size() != 0) begin
            bad++; $display("FAIL bad_magic_out: got data=%0d ctrl=%0d, required 0 0", dq.size(), cq.size());
        end
        total++;
        if (err_count_o !== 16'd1) begin
            bad++; $display("FAIL bad_magic_err: got %0d, required 1", err_count_o);
        end
        total++;
        if (s_hdr_tready !== 1'b1) begin
            bad++; $display("FAIL bad_magic_idle: got %b, required 1", s_hdr_tready);
        end
    endtask

    task automatic test_seq_err();
        logic [63:0] base = 64'h3333_0000_0000_0000;
        logic [73:0] e;
        apply_reset();
        send_dgram(16'd80, 64'hDA7A0000_12300064, 9, 8'hFF, base);
        send_dgram(16'd36, 64'hDA7A0002_12300064, 4, 8'h0F, 64'h4444);
        settle();
        total++;
        if (dq.size() != 10) begin
            bad++; $display("FAIL seq_err_count: got %0d, required 10", dq.size());
        end
        for (int j = 0; j < 10 && j < dq.size(); j++) begin
            e = j == 9 ? {1'b1, 1'b1, 8'h00, 64'd0} : {1'b0, 1'b0, 8'hFF, base + 64'(j)};
            total++;
            if (dq[j] !== e) begin
                bad++; $display("FAIL seq_err_beat%0d: got %h, required %h", j, dq[j], e);
            end
        end
        total++;
        if (cq.size() != 1 || cq[0] !== {1'b1, 32'h12300064}) begin
            bad++; $display("FAIL seq_err_ctrl: got n=%0d %h, required n=1 112300064", cq.size(), cq.size() ? cq[0] : 33'h0);
        end
        total++;
        if (err_count_o !== 16'd1 || s_hdr_tready !== 1'b1) begin
            bad++; $display("FAIL seq_err_state: got err=%0d hdr_rdy=%b, required 1 1", err_count_o, s_hdr_tready);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] base = 64'h5555_0000_0000_0000;
        logic [73:0] e;
        apply_reset();
        tog_en = 1'b1;
        send_dgram(16'd80, 64'hDA7A0000_12300064, 9, 8'hFF, base);
        send_dgram(16'd36, 64'hDA7A0001_12300064, 4, 8'h0F, base + 64'd9);
        settle();
        tog_en = 1'b0;
        total++;
        if (dq.size() != 13) begin
            bad++; $display("FAIL bp_count: got %0d, required 13", dq.size());
        end
        for (int j = 0; j < 13 && j < dq.size(); j++) begin
            e = {1'b0, j == 12, j == 12 ? 8'h0F : 8'hFF, base + 64'(j)};
            total++;
            if (dq[j] !== e) begin
                bad++; $display("FAIL bp_beat%0d: got %h, required %h", j, dq[j], e);
            end
        end
        total++;
        if (cq.size() != 1 || cq[0] !== {1'b0, 32'h12300064}) begin
            bad++; $display("FAIL bp_ctrl: got n=%0d, required n=1 012300064", cq.size());
        end
    endtask

    task automatic test_single();
        apply_reset();
        send_dgram(16'd16, 64'hDA7A0000_45600008, 1, 8'hFF, 64'h6666);
        settle();
        total++;
        if (dq.size() != 1 || dq[0] !== {1'b0, 1'b1, 8'hFF, 64'h6666}) begin
            bad++; $display("FAIL single_beat: got n=%0d, required n=1 with tlast", dq.size());
        end
        total++;
        if (cq.size() != 1 || cq[0] !== {1'b0, 32'h45600008}) begin
            bad++; $display("FAIL single_ctrl: got n=%0d, required n=1 045600008", cq.size());
        end
    endtask

    task automatic test_short_hdr();
        apply_reset();
        send_hdr(16'd8);
        send_beat(64'hDA7A0000_45600008, 8'hFF, 1'b1);
        settle();
        total++;
        if (dq.size() != 0 || cq.size() != 0 || s_hdr_tready !== 1'b1) begin
            bad++; $display("FAIL short_hdr: got data=%0d ctrl=%0d hdr_rdy=%b, required 0 0 1", dq.size(), cq.size(), s_hdr_tready);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send_hdr(16'd80);
        send_beat(64'hDA7A0000_12300064, 8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) send_beat(64'h7777 + 64'(i), 8'hFF, 1'b0);
        s_payload_tvalid = 1'b1;
        aresetn = 1'b0;
        @(negedge aclk);
        total++;
        if ({m_data_tvalid, s_payload_tready, s_hdr_tready} !== 3'b000) begin
            bad++; $display("FAIL reset_mid_outputs: got %b, required 000", {m_data_tvalid, s_payload_tready, s_hdr_tready});
        end
        apply_reset();
        send_dgram(16'd16, 64'hDA7A0000_45600008, 1, 8'hFF, 64'h8888);
        settle();
        total++;
        if (dq.size() != 1 || dq[0] !== {1'b0, 1'b1, 8'hFF, 64'h8888}) begin
            bad++; $display("FAIL reset_mid_beat: got n=%0d, required n=1 clean beat", dq.size());
        end
        total++;
        if (cq.size() != 1 || cq[0] !== {1'b0, 32'h45600008} || err_count_o !== 16'd0) begin
            bad++; $display("FAIL reset_mid_ctrl: got n=%0d err=%0d, required n=1 err=0", cq.size(), err_count_o);
        end
    endtask

    initial begin
        test_reset();
        test_two_frag();
        test_bad_magic();
        test_seq_err();
        test_backpressure();
        test_single();
        test_short_hdr();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
